// File: rtl/risc_pkg.sv
// Shared definitions for the multicycle RISC sequencer: state encodings,
// opcode/funct constants, next-PC select codes and opcode classification.
package risc_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    CLS_MEM,
    CLS_WB,
    CLS_CTRL,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] PC_INC  = 3'b000;
  localparam logic [2:0] PC_JUMP = 3'b001;
  localparam logic [2:0] PC_JR   = 3'b010;
  localparam logic [2:0] PC_BEQ  = 3'b011;
  localparam logic [2:0] PC_BNE  = 3'b100;

  // Decide which path an instruction takes after EXECUTE.
  function automatic op_class_t classify(input logic [5:0] op, input logic [5:0] funct);
    if (op == OP_LW || op == OP_SW) return CLS_MEM;
    if (op == OP_RTYPE) return (funct == FN_JR) ? CLS_CTRL : CLS_WB;
    // immediate ALU group 0x08-0x0F shares the upper opcode bits with ADDI
    if (op == OP_JAL || op[5:3] == OP_ADDI[5:3]) return CLS_WB;
    if (op == OP_J || op == OP_BEQ || op == OP_BNE) return CLS_CTRL;
    return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/seq_perf_counter.sv
// Performance counters for the sequencer: total active cycles and retired
// instructions, both wrapping at 2^CNT_W.
module seq_perf_counter
  import risc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cycle_en,
  input  logic             instr_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  // Count enabled cycles and retire strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (cycle_en) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_en) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle sequencer: steps each instruction through FETCH, DECODE, EXECUTE,
// MEM and WRITEBACK, gates the decoder's write/PC enables to one cycle per
// instruction and runs the req/ack handshakes to both memories with a timeout.
// Optional feature macro: SEQ_PERF_CNT_EN adds cycle_cnt/instr_cnt outputs.
module multicycle_sequencer
  import risc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] instruction,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_load,
  output logic        dmem_req,
  input  logic        dmem_ack,
  input  logic [3:0]  dec_data_mem_wren,
  input  logic        dec_file_wren,
  input  logic [2:0]  dec_pc_control,
  output logic [3:0]  data_mem_wren,
  output logic        file_wren,
  output logic        pc_wren,
  output logic [2:0]  pc_control,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state_o
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  // Counter only needs to hold TIMEOUT-1: the cycle that would reach TIMEOUT halts.
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  seq_state_t      state, state_nxt;
  op_class_t       cls;
  logic            fetch_pend, fetch_pend_nxt;
  logic [TO_W-1:0] wait_cnt;
  logic            waiting, timeout_hit, is_sw, bus_err_q;
  logic            unused_bits;

  assign unused_bits = ^{instruction[25:6], (CNT_W == 0)};
  assign state_o     = state;
  assign bus_err     = bus_err_q;

  // State, pending-fetch flag, wait counter and sticky bus error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      fetch_pend <= 1'b0;
      wait_cnt   <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pend <= fetch_pend_nxt;
      wait_cnt   <= (waiting && !timeout_hit) ? wait_cnt + TO_W'(1) : '0;
      if (timeout_hit) bus_err_q <= 1'b1;
    end
  end

  // Next state and gated outputs; reset forces every output low combinationally.
  always_comb begin
    state_nxt      = state;
    fetch_pend_nxt = 1'b0;
    waiting        = 1'b0;
    imem_req       = 1'b0;
    ir_load        = 1'b0;
    dmem_req       = 1'b0;
    data_mem_wren  = '0;
    file_wren      = 1'b0;
    pc_wren        = 1'b0;
    pc_control     = PC_INC;
    illegal        = 1'b0;
    cls            = classify(instruction[31:26], instruction[5:0]);
    is_sw          = (instruction[31:26] == OP_SW);

    case (state)
      S_FETCH: begin
        // once raised, the fetch request is held even if run drops
        imem_req = run || fetch_pend;
        if (imem_req && imem_ack) begin
          ir_load   = 1'b1;
          state_nxt = S_DECODE;
        end
        waiting        = imem_req && !imem_ack;
        fetch_pend_nxt = waiting;
      end
      S_DECODE: state_nxt = S_EXECUTE;
      S_EXECUTE: begin
        case (cls)
          CLS_MEM: state_nxt = S_MEM;
          CLS_WB:  state_nxt = S_WRITEBACK;
          CLS_CTRL: begin
            pc_wren    = 1'b1;
            pc_control = dec_pc_control;
            state_nxt  = S_FETCH;
          end
          default: begin
            illegal   = 1'b1;
            pc_wren   = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (is_sw) data_mem_wren = dec_data_mem_wren;
        waiting = !dmem_ack;
        if (dmem_ack) begin
          if (is_sw) begin
            pc_wren    = 1'b1;
            pc_control = dec_pc_control;
            state_nxt  = S_FETCH;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        file_wren  = dec_file_wren;
        pc_wren    = 1'b1;
        pc_control = dec_pc_control;
        state_nxt  = S_FETCH;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase

    // an ack in the limit cycle clears waiting, so it wins over the timeout
    timeout_hit = (TIMEOUT != 0) && waiting && (wait_cnt == TO_LIMIT);
    if (timeout_hit) begin
      state_nxt      = S_HALT;
      fetch_pend_nxt = 1'b0;
    end

    if (reset) begin
      imem_req      = 1'b0;
      ir_load       = 1'b0;
      dmem_req      = 1'b0;
      data_mem_wren = '0;
      file_wren     = 1'b0;
      pc_wren       = 1'b0;
      pc_control    = PC_INC;
      illegal       = 1'b0;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  seq_perf_counter #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk       (clk),
    .reset     (reset),
    .cycle_en  (state != S_HALT),
    .instr_en  (pc_wren),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );
`endif

endmodule
